// File: rtl/parity_stream_gen_check.sv
// parity_stream_gen_check
//   Two independent one-entry valid/ready stages sharing a clock:
//   - generator: registers each accepted word together with its parity bit
//   - checker:   registers each accepted word together with a mismatch flag
//   Parity sense is even for ODD=0 and odd for ODD=1.
//   The sticky error flag and the optional error counter track checker
//   error events.
//   Optional feature macro: PARITY_ERR_CNT_EN adds the err_cnt port and a
//   saturating error counter of width CNT_W.
module parity_stream_gen_check #(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gen_valid,
  input  logic [DATA_W-1:0] gen_data,
  output logic              gen_ready,
  output logic              gen_out_valid,
  output logic [DATA_W-1:0] gen_out_data,
  output logic              gen_out_p,
  input  logic              gen_out_ready,
  input  logic              chk_valid,
  input  logic [DATA_W-1:0] chk_data,
  input  logic              chk_p,
  output logic              chk_ready,
  output logic              chk_out_valid,
  output logic [DATA_W-1:0] chk_out_data,
  output logic              chk_out_err,
  input  logic              chk_out_ready,
  input  logic              err_clr,
  output logic              err_sticky
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  // Reject meaningless widths at elaboration time.
  if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
    $error("parity_stream_gen_check: DATA_W and CNT_W must be >= 1");
  end

  logic              gen_vld_q;
  logic [DATA_W-1:0] gen_dat_q;
  logic              gen_p_q;
  logic              chk_vld_q;
  logic [DATA_W-1:0] chk_dat_q;
  logic              chk_err_q;
  logic              sticky_q;
  logic              sticky_d;

  logic gen_acc;
  logic chk_acc;
  logic gen_par;
  logic chk_bad;
  logic err_evt;

  // Ready depends only on reset and the output side, never on input valid.
  always_comb begin
    gen_ready = !rst && (!gen_vld_q || gen_out_ready);
    chk_ready = !rst && (!chk_vld_q || chk_out_ready);
    gen_acc   = gen_valid && gen_ready;
    chk_acc   = chk_valid && chk_ready;
    gen_par   = (^gen_data) ^ ODD;
    chk_bad   = (^chk_data) ^ chk_p ^ ODD;
    err_evt   = chk_acc && chk_bad;
  end

  // Generator stage: load on accept, drop valid on a drain-only handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_vld_q <= 1'b0;
      gen_dat_q <= '0;
      gen_p_q   <= 1'b0;
    end else if (gen_acc) begin
      gen_vld_q <= 1'b1;
      gen_dat_q <= gen_data;
      gen_p_q   <= gen_par;
    end else if (gen_vld_q && gen_out_ready) begin
      gen_vld_q <= 1'b0;
    end
  end

  // Checker stage: load on accept, drop valid on a drain-only handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_vld_q <= 1'b0;
      chk_dat_q <= '0;
      chk_err_q <= 1'b0;
    end else if (chk_acc) begin
      chk_vld_q <= 1'b1;
      chk_dat_q <= chk_data;
      chk_err_q <= chk_bad;
    end else if (chk_vld_q && chk_out_ready) begin
      chk_vld_q <= 1'b0;
    end
  end

  // Sticky next state: an error event outranks a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (err_evt) begin
      sticky_d = 1'b1;
    end else if (err_clr) begin
      sticky_d = 1'b0;
    end
  end

  // Sticky error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter next state: clear (loading 1 if an error coincides), else
  // saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = err_evt ? CNT_W'(1) : '0;
    end else if (err_evt && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`endif

  assign gen_out_valid = gen_vld_q;
  assign gen_out_data  = gen_dat_q;
  assign gen_out_p     = gen_p_q;
  assign chk_out_valid = chk_vld_q;
  assign chk_out_data  = chk_dat_q;
  assign chk_out_err   = chk_err_q;
  assign err_sticky    = sticky_q;

endmodule

// File: tb/tb_parity_stream_gen_check.sv
// Bench for parity_stream_gen_check: an even-parity and an odd-parity
// instance share all inputs; a behavioural model predicts both.
module tb_parity_stream_gen_check;

  localparam int CMAX = 3;  // CNT_W=2 saturation value

  logic       clk = 1'b0;
  logic       rst;
  logic       gen_valid, gen_out_ready, chk_valid, chk_p, chk_out_ready, err_clr;
  logic [7:0] gen_data, chk_data;

  logic       e_gen_ready, e_gen_out_valid, e_gen_out_p, e_chk_ready, e_chk_out_valid, e_chk_out_err, e_err_sticky;
  logic [7:0] e_gen_out_data, e_chk_out_data;
  logic       o_gen_ready, o_gen_out_valid, o_gen_out_p, o_chk_ready, o_chk_out_valid, o_chk_out_err, o_err_sticky;
  logic [7:0] o_gen_out_data, o_chk_out_data;
`ifdef PARITY_ERR_CNT_EN
  logic [1:0] e_err_cnt, o_err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Model state: handshakes are identical for both instances; parity results differ.
  bit       m_gv, m_cv, m_gclean, m_cclean;
  bit [7:0] m_gd, m_cd;
  bit       m_gp[2], m_ce[2], m_st[2];
  int       m_cnt[2];

  always #5 clk = ~clk;

  parity_stream_gen_check #(.DATA_W(8), .ODD(1'b0), .CNT_W(2)) u_even (
    .clk(clk), .rst(rst),
    .gen_valid(gen_valid), .gen_data(gen_data), .gen_ready(e_gen_ready),
    .gen_out_valid(e_gen_out_valid), .gen_out_data(e_gen_out_data), .gen_out_p(e_gen_out_p),
    .gen_out_ready(gen_out_ready),
    .chk_valid(chk_valid), .chk_data(chk_data), .chk_p(chk_p), .chk_ready(e_chk_ready),
    .chk_out_valid(e_chk_out_valid), .chk_out_data(e_chk_out_data), .chk_out_err(e_chk_out_err),
    .chk_out_ready(chk_out_ready),
    .err_clr(err_clr), .err_sticky(e_err_sticky)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(e_err_cnt)
`endif
  );

  parity_stream_gen_check #(.DATA_W(8), .ODD(1'b1), .CNT_W(2)) u_odd (
    .clk(clk), .rst(rst),
    .gen_valid(gen_valid), .gen_data(gen_data), .gen_ready(o_gen_ready),
    .gen_out_valid(o_gen_out_valid), .gen_out_data(o_gen_out_data), .gen_out_p(o_gen_out_p),
    .gen_out_ready(gen_out_ready),
    .chk_valid(chk_valid), .chk_data(chk_data), .chk_p(chk_p), .chk_ready(o_chk_ready),
    .chk_out_valid(o_chk_out_valid), .chk_out_data(o_chk_out_data), .chk_out_err(o_chk_out_err),
    .chk_out_ready(chk_out_ready),
    .err_clr(err_clr), .err_sticky(o_err_sticky)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(o_err_cnt)
`endif
  );

  // Parity from a population count: even sense gives 1 for an odd number of ones.
  function automatic bit par(input bit [7:0] d, input int odd);
    return bit'(($countones(d) % 2) != 0) ^ bit'(odd);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every registered output of both instances with the model.
  task automatic compare_outputs();
    cmp("e_gen_out_valid", 32'(e_gen_out_valid), 32'(m_gv));
    cmp("o_gen_out_valid", 32'(o_gen_out_valid), 32'(m_gv));
    cmp("e_chk_out_valid", 32'(e_chk_out_valid), 32'(m_cv));
    cmp("o_chk_out_valid", 32'(o_chk_out_valid), 32'(m_cv));
    if (m_gv || m_gclean) begin
      cmp("e_gen_out_data", 32'(e_gen_out_data), 32'(m_gd));
      cmp("o_gen_out_data", 32'(o_gen_out_data), 32'(m_gd));
      cmp("e_gen_out_p", 32'(e_gen_out_p), 32'(m_gp[0]));
      cmp("o_gen_out_p", 32'(o_gen_out_p), 32'(m_gp[1]));
    end
    if (m_cv || m_cclean) begin
      cmp("e_chk_out_data", 32'(e_chk_out_data), 32'(m_cd));
      cmp("o_chk_out_data", 32'(o_chk_out_data), 32'(m_cd));
      cmp("e_chk_out_err", 32'(e_chk_out_err), 32'(m_ce[0]));
      cmp("o_chk_out_err", 32'(o_chk_out_err), 32'(m_ce[1]));
    end
    cmp("e_err_sticky", 32'(e_err_sticky), 32'(m_st[0]));
    cmp("o_err_sticky", 32'(o_err_sticky), 32'(m_st[1]));
`ifdef PARITY_ERR_CNT_EN
    cmp("e_err_cnt", 32'(e_err_cnt), 32'(m_cnt[0]));
    cmp("o_err_cnt", 32'(o_err_cnt), 32'(m_cnt[1]));
`endif
  endtask

  // One clock: inputs were driven at the preceding negedge. Check readies,
  // predict the edge, then check registered outputs; returns at the next negedge.
  task automatic step();
    bit gr, cr, gacc, cacc;
    bit ev[2];
    #1;
    gr = !rst && (!m_gv || gen_out_ready);
    cr = !rst && (!m_cv || chk_out_ready);
    cmp("e_gen_ready", 32'(e_gen_ready), 32'(gr));
    cmp("o_gen_ready", 32'(o_gen_ready), 32'(gr));
    cmp("e_chk_ready", 32'(e_chk_ready), 32'(cr));
    cmp("o_chk_ready", 32'(o_chk_ready), 32'(cr));
    gacc = gen_valid && gr;
    cacc = chk_valid && cr;
    for (int k = 0; k < 2; k++) ev[k] = cacc && (par(chk_data, k) ^ chk_p);
    @(posedge clk);
    if (rst) begin
      m_gv = 0; m_cv = 0; m_gd = '0; m_cd = '0; m_gclean = 1; m_cclean = 1;
      for (int k = 0; k < 2; k++) begin
        m_gp[k] = 0; m_ce[k] = 0; m_st[k] = 0; m_cnt[k] = 0;
      end
    end else begin
      if (gacc) begin
        m_gv = 1; m_gd = gen_data; m_gclean = 0;
        for (int k = 0; k < 2; k++) m_gp[k] = par(gen_data, k);
      end else if (m_gv && gen_out_ready) begin
        m_gv = 0; m_gclean = 0;
      end
      if (cacc) begin
        m_cv = 1; m_cd = chk_data; m_cclean = 0;
        for (int k = 0; k < 2; k++) m_ce[k] = par(chk_data, k) ^ chk_p;
      end else if (m_cv && chk_out_ready) begin
        m_cv = 0; m_cclean = 0;
      end
      for (int k = 0; k < 2; k++) begin
        if (ev[k]) m_st[k] = 1;
        else if (err_clr) m_st[k] = 0;
        if (err_clr) m_cnt[k] = ev[k] ? 1 : 0;
        else if (ev[k] && m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
      end
    end
    #1;
    compare_outputs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    gen_valid = 0; gen_data = '0; gen_out_ready = 1;
    chk_valid = 0; chk_data = '0; chk_p = 0; chk_out_ready = 1; err_clr = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    @(negedge clk);

    // Reset for two cycles with activity on the inputs.
    gen_valid = 1; gen_data = 8'hFF; chk_valid = 1; chk_data = 8'h01; chk_p = 0;
    step();
    cmp("rst_gen_ready", 32'(e_gen_ready), 32'h0);
    step();
    cmp("rst_valid", 32'(e_gen_out_valid), 32'h0);
    cmp("rst_sticky", 32'(e_err_sticky), 32'h0);
    rst = 0;
    idle_inputs();
    #1;
    cmp("post_rst_gen_ready", 32'(e_gen_ready), 32'h1);
    cmp("post_rst_chk_ready", 32'(e_chk_ready), 32'h1);
    @(negedge clk);

    // Even generator, back-to-back words.
    gen_valid = 1; gen_data = 8'hA5;
    step();
    cmp("lit_A5_p_even", 32'(e_gen_out_p), 32'h0);
    cmp("lit_A5_data", 32'(e_gen_out_data), 32'hA5);
    gen_data = 8'h07;
    step();
    cmp("lit_07_p_even", 32'(e_gen_out_p), 32'h1);
    cmp("lit_07_p_odd", 32'(o_gen_out_p), 32'h0);

    // Backpressure: 3C is held while downstream stalls for three cycles.
    gen_data = 8'h3C;
    step();
    gen_out_ready = 0; gen_data = 8'h11;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      cmp("lit_bp_ready", 32'(e_gen_ready), 32'h0);
      cmp("lit_bp_hold", 32'(e_gen_out_data), 32'h3C);
      @(negedge clk);
    end
    gen_out_ready = 1; gen_data = 8'h55;
    step();
    cmp("lit_release_data", 32'(e_gen_out_data), 32'h55);
    gen_valid = 0;
    step();
    cmp("lit_drain_valid", 32'(e_gen_out_valid), 32'h0);

    // Checker and sticky flag.
    chk_valid = 1; chk_data = 8'hA5; chk_p = 1;
    step();
    cmp("lit_chk_err", 32'(e_chk_out_err), 32'h1);
    cmp("lit_sticky_set", 32'(e_err_sticky), 32'h1);
    chk_p = 0;
    step();
    cmp("lit_chk_ok", 32'(e_chk_out_err), 32'h0);
    cmp("lit_sticky_held", 32'(e_err_sticky), 32'h1);
    chk_valid = 0; err_clr = 1;
    step();
    cmp("lit_sticky_clr", 32'(e_err_sticky), 32'h0);
    err_clr = 0;

    // Odd mode on the second instance.
    gen_valid = 1; gen_data = 8'h00; chk_valid = 1; chk_data = 8'h00; chk_p = 1;
    step();
    cmp("lit_odd_p_00", 32'(o_gen_out_p), 32'h1);
    cmp("lit_odd_chk_00", 32'(o_chk_out_err), 32'h0);
    cmp("lit_even_chk_00", 32'(e_chk_out_err), 32'h1);
    gen_valid = 0; chk_valid = 0; err_clr = 1;
    step();
    err_clr = 0;

`ifdef PARITY_ERR_CNT_EN
    // Saturation with CNT_W=2, then clear coinciding with an error.
    chk_valid = 1; chk_data = 8'hA5; chk_p = 1;
    for (int i = 0; i < 5; i++) step();
    cmp("lit_cnt_sat", 32'(e_err_cnt), 32'h3);
    err_clr = 1;
    step();
    cmp("lit_cnt_clr_err", 32'(e_err_cnt), 32'h1);
    err_clr = 0; chk_valid = 0;
    step();
`endif

    // Randomized traffic with occasional reset and clear.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(99) == 0);
      gen_valid     = $urandom_range(1);
      gen_data      = 8'($urandom);
      gen_out_ready = ($urandom_range(3) != 0);
      chk_valid     = $urandom_range(1);
      chk_data      = 8'($urandom);
      chk_p         = $urandom_range(1);
      chk_out_ready = ($urandom_range(3) != 0);
      err_clr       = ($urandom_range(19) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
